// File: rtl/stdout_drain_fmt_if.sv
// -----------------------------------------------------------------------------
// stdout_drain_fmt_if
// Purpose : bundles the FIFO-side pop handshake and the byte-stream handshake
//           of the stdout drain formatter.
// Signals : fifo_valid_i  - FWFT FIFO head valid          (master -> slave)
//           fifo_data_i   - FIFO head entry, 32 bits      (master -> slave)
//           fifo_rd_en_o  - one-cycle pop of the head     (slave  -> master)
//           tx_valid_o    - byte-stream valid             (slave  -> master)
//           tx_data_o     - byte-stream data, 8 bits      (slave  -> master)
//           tx_ready_i    - byte-stream ready             (master -> slave)
// The slave modport is the formatter; the master modport is its environment.
// -----------------------------------------------------------------------------
interface stdout_drain_fmt_if;
  logic        fifo_valid_i;
  logic [31:0] fifo_data_i;
  logic        fifo_rd_en_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;

  modport slave (
    input  fifo_valid_i, fifo_data_i, tx_ready_i,
    output fifo_rd_en_o, tx_valid_o, tx_data_o
  );

  modport master (
    output fifo_valid_i, fifo_data_i, tx_ready_i,
    input  fifo_rd_en_o, tx_valid_o, tx_data_o
  );
endinterface

// File: rtl/stdout_drain_fmt.sv
// -----------------------------------------------------------------------------
// stdout_drain_fmt
// Purpose : drains per-core stdout characters from a FWFT FIFO and formats them
//           into a byte stream. A "[cluster,core] " prefix is emitted whenever a
//           new line starts or the source changes; a source change on an open
//           line first terminates that line with LF. Out-of-range entries are
//           popped and counted as drops.
// Ports   : clk_i      - clock, rising edge
//           rst_ni     - asynchronous active-low reset
//           enable_i   - permits latching new FIFO entries
//           bus        - FIFO pop + byte-stream handshake (slave modport)
//           busy_o     - high whenever an entry is being emitted
//           drop_cnt_o - saturating count of dropped entries
// -----------------------------------------------------------------------------
module stdout_drain_fmt #(
  parameter int N_CLUSTERS = 1,
  parameter int N_CORES    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  stdout_drain_fmt_if.slave        bus,
  output logic                     busy_o,
  output logic [15:0]              drop_cnt_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SEP_LF  = 4'd1,
    P_OPEN  = 4'd2,
    P_CL    = 4'd3,
    P_COMMA = 4'd4,
    P_CORE  = 4'd5,
    P_CLOSE = 4'd6,
    P_SPACE = 4'd7,
    CHAR    = 4'd8
  } state_e;

  localparam logic [7:0] L_N_CL   = 8'(N_CLUSTERS);
  localparam logic [7:0] L_N_CORE = 8'(N_CORES);

  // Lowercase ASCII hex digit of a nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h57 + {4'h0, n};
    end
    return c;
  endfunction

  // Byte presented on the stream for a given state and latched entry.
  function automatic logic [7:0] state_byte(input state_e st, input logic [23:0] ent);
    logic [7:0] b;
    case (st)
      SEP_LF:  b = 8'h0A;
      P_OPEN:  b = 8'h5B;
      P_CL:    b = hex_char(ent[19:16]);
      P_COMMA: b = 8'h2C;
      P_CORE:  b = hex_char(ent[11:8]);
      P_CLOSE: b = 8'h5D;
      P_SPACE: b = 8'h20;
      CHAR:    b = ent[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_e      r_state;
  state_e      w_next_state;
  logic [23:0] r_entry;
  logic [23:0] w_next_entry;
  logic [7:0]  w_next_byte;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_line_open;
  logic [3:0]  r_last_cl;
  logic [3:0]  r_last_core;
  logic [15:0] r_drop_cnt;
  logic        w_pop;
  logic        w_in_range;
  logic        w_src_change;
  logic        w_hs;
  logic        w_drop;
  logic [7:0]  w_cl;
  logic [7:0]  w_core;

  assign w_cl         = bus.fifo_data_i[23:16];
  assign w_core       = bus.fifo_data_i[15:8];
  assign w_in_range   = (w_cl < L_N_CL) && (w_core < L_N_CORE);
  assign w_src_change = {w_cl[3:0], w_core[3:0]} != {r_last_cl, r_last_core};
  // Pop is combinational so the head leaves the FIFO in the same cycle it is latched;
  // gated by rst_ni so nothing is popped while reset is held.
  assign w_pop        = rst_ni && (r_state == IDLE) && enable_i && bus.fifo_valid_i;
  assign w_hs         = r_tx_valid && bus.tx_ready_i;

  // Next-state, next latched entry and drop decision.
  always_comb begin
    w_next_state = r_state;
    w_next_entry = r_entry;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          if (w_in_range) begin
            w_next_entry = bus.fifo_data_i[23:0];
            if (r_line_open && w_src_change) begin
              w_next_state = SEP_LF;
            end else if (!r_line_open || w_src_change) begin
              w_next_state = P_OPEN;
            end else begin
              w_next_state = CHAR;
            end
          end else begin
            w_drop = 1'b1;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      SEP_LF:  if (w_hs) w_next_state = P_OPEN;  else w_next_state = SEP_LF;
      P_OPEN:  if (w_hs) w_next_state = P_CL;    else w_next_state = P_OPEN;
      P_CL:    if (w_hs) w_next_state = P_COMMA; else w_next_state = P_CL;
      P_COMMA: if (w_hs) w_next_state = P_CORE;  else w_next_state = P_COMMA;
      P_CORE:  if (w_hs) w_next_state = P_CLOSE; else w_next_state = P_CORE;
      P_CLOSE: if (w_hs) w_next_state = P_SPACE; else w_next_state = P_CLOSE;
      P_SPACE: if (w_hs) w_next_state = CHAR;    else w_next_state = P_SPACE;
      CHAR:    if (w_hs) w_next_state = IDLE;    else w_next_state = CHAR;
      default: w_next_state = IDLE;
    endcase
    w_next_byte = state_byte(w_next_state, w_next_entry);
  end

  // State, latched entry and registered stream outputs (byte precomputed from next state).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_entry    <= 24'h000000;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_next_state;
      r_entry    <= w_next_entry;
      r_tx_valid <= (w_next_state != IDLE);
      r_tx_data  <= w_next_byte;
    end
  end

  // Line tracking: LF separator closes the line, the character decides if it stays open.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_line_open <= 1'b0;
      r_last_cl   <= 4'h0;
      r_last_core <= 4'h0;
    end else if (w_hs && (r_state == SEP_LF)) begin
      r_line_open <= 1'b0;
    end else if (w_hs && (r_state == CHAR)) begin
      r_line_open <= (r_entry[7:0] != 8'h0A);
      r_last_cl   <= r_entry[19:16];
      r_last_core <= r_entry[11:8];
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= 16'h0000;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'h0001;
    end
  end

  assign bus.fifo_rd_en_o = w_pop;
  assign bus.tx_valid_o   = r_tx_valid;
  assign bus.tx_data_o    = r_tx_data;
  assign busy_o           = (r_state != IDLE);
  assign drop_cnt_o       = r_drop_cnt;

endmodule

// File: tb/tb_stdout_drain_fmt.sv
// -----------------------------------------------------------------------------
// tb_stdout_drain_fmt
// Self-checking bench: a FIFO model feeds entries, expected bytes are queued
// when an entry is offered and compared as the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_stdout_drain_fmt;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        busy;
  logic [15:0] drop_cnt;

  stdout_drain_fmt_if bus ();

  stdout_drain_fmt #(.N_CLUSTERS(16), .N_CORES(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .bus        (bus),
    .busy_o     (busy),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    string       exp;
    bit          drop;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int exp_pops = 0;
  int exp_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic add_vec(input logic [31:0] w, input string s, input bit d);
    vec_t v;
    v.word = w;
    v.exp  = s;
    v.drop = d;
    vecs.push_back(v);
  endtask

  task automatic refresh_fifo();
    bus.fifo_valid_i = (fifo_q.size() > 0);
    bus.fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push_entry(input logic [31:0] w, input string s, input bit d);
    fifo_q.push_back(w);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (d && exp_drop < 65535) exp_drop++;
    exp_pops++;
    refresh_fifo();
  endtask

  // One clock: sample at negedge, FIFO model update just after posedge.
  task automatic tick();
    bit popped;
    @(negedge clk);
    popped = bus.fifo_rd_en_o;
    if (popped) begin
      chk("pop_needs_valid", 32'(bus.fifo_valid_i), 32'h1);
      chk("pop_only_idle", 32'(busy), 32'h0);
      n_pops++;
    end
    if (bus.tx_valid_o && bus.tx_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data_o);
      end else begin
        chk("tx_byte", 32'(bus.tx_data_o), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    while (i < bound && !(fifo_q.size() == 0 && !busy)) begin
      tick();
      i++;
    end
    if (!(fifo_q.size() == 0 && !busy)) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: fifo=%0d busy=%0b", fifo_q.size(), busy);
    end
    chk("bytes_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
  endtask

  initial begin
    int pops0;
    rst_n            = 1'b0;
    enable           = 1'b1;
    bus.tx_ready_i   = 1'b1;
    bus.fifo_valid_i = 1'b1;
    bus.fifo_data_i  = 32'h00000248;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid_o), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data_o), 32'h0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en_o), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    refresh_fifo();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sequential vectors; line state carries from one to the next.
    add_vec(32'h00000248, "[0,2] H", 1'b0);
    add_vec(32'h0000020A, "\n", 1'b0);
    add_vec(32'h00000241, "[0,2] A", 1'b0);
    add_vec(32'h00000342, "\n[0,3] B", 1'b0);
    add_vec(32'h00000343, "C", 1'b0);
    add_vec(32'h00000941, "", 1'b1);
    add_vec(32'h00001041, "", 1'b1);
    add_vec(32'h00100041, "", 1'b1);
    add_vec(32'h00FF0041, "", 1'b1);
    add_vec(32'hFF00070A, "\n[0,7] \n", 1'b0);
    add_vec(32'h0000070A, "[0,7] \n", 1'b0);
    add_vec(32'h000A0146, "[a,1] F", 1'b0);
    add_vec(32'h000F0746, "\n[f,7] F", 1'b0);
    add_vec(32'h00090544, "\n[9,5] D", 1'b0);
    add_vec(32'h00090545, "E", 1'b0);
    for (int v = 0; v < vecs.size(); v++) begin
      push_entry(vecs[v].word, vecs[v].exp, vecs[v].drop);
      drain(100);
    end

    // Same source, open line: byte at t+1, idle at t+2.
    push_entry(32'h00090546, "", 1'b0);
    @(negedge clk);
    chk("lat_pop", 32'(bus.fifo_rd_en_o), 32'h1);
    n_pops++;
    @(posedge clk);
    #1;
    void'(fifo_q.pop_front());
    refresh_fifo();
    chk("lat_valid_t1", 32'(bus.tx_valid_o), 32'h1);
    chk("lat_data_t1", 32'(bus.tx_data_o), 32'h46);
    @(posedge clk);
    #1;
    chk("lat_idle_t2", 32'(busy), 32'h0);
    chk("lat_valid_t2", 32'(bus.tx_valid_o), 32'h0);

    // Back-to-back entries: next latch in the cycle IDLE is re-entered.
    pops0 = n_pops;
    push_entry(32'h00090547, "G", 1'b0);
    push_entry(32'h00090548, "H", 1'b0);
    repeat (4) tick();
    chk("b2b_idle", 32'(busy), 32'h0);
    chk("b2b_pops", 32'(n_pops - pops0), 32'h2);
    chk("b2b_bytes_left", 32'(exp_q.size()), 32'h0);

    // Stall in P_CL with a second entry waiting at the FIFO head.
    bus.tx_ready_i = 1'b0;
    push_entry(32'h000C0348, "\n[c,3] H", 1'b0);
    push_entry(32'h000C0349, "I", 1'b0);
    tick();
    bus.tx_ready_i = 1'b1;
    tick();
    tick();
    bus.tx_ready_i = 1'b0;
    pops0 = n_pops;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_data", 32'(bus.tx_data_o), 32'h63);
      chk("stall_valid", 32'(bus.tx_valid_o), 32'h1);
    end
    chk("stall_no_pop", 32'(n_pops - pops0), 32'h0);
    bus.tx_ready_i = 1'b1;
    drain(100);

    // enable low blocks latching but never aborts an entry in flight.
    enable = 1'b0;
    pops0 = n_pops;
    push_entry(32'h000C034A, "J", 1'b0);
    repeat (3) tick();
    chk("en_off_no_pop", 32'(n_pops - pops0), 32'h0);
    chk("en_off_idle", 32'(busy), 32'h0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    push_entry(32'h000C034B, "K", 1'b0);
    repeat (4) tick();
    chk("en_mid_done", 32'(busy), 32'h0);
    chk("en_mid_fifo", 32'(fifo_q.size()), 32'h1);
    chk("en_mid_bytes", 32'(exp_q.size()), 32'h1);
    enable = 1'b1;
    drain(100);

    // Reset in P_COMMA drops the rest of the entry and the line state.
    push_entry(32'h00000148, "\n[0", 1'b0);
    repeat (4) tick();
    chk("pre_rst_data", 32'(bus.tx_data_o), 32'h2C);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.tx_valid_o), 32'h0);
    chk("async_rst_data", 32'(bus.tx_data_o), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_bytes_left", 32'(exp_q.size()), 32'h0);
    exp_drop = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_entry(32'h00000149, "[0,1] I", 1'b0);
    drain(100);

    // Drop counter increments once then saturates.
    push_entry(32'h00000941, "", 1'b1);
    drain(100);
    chk("drop_one", 32'(drop_cnt), 32'h1);
    pops0 = n_pops;
    for (int k = 0; k < 65535; k++) push_entry(32'h00000941, "", 1'b1);
    drain(70000);
    chk("drop_pops", 32'(n_pops - pops0), 32'd65535);
    chk("drop_sat", 32'(drop_cnt), 32'hFFFF);
    push_entry(32'h00000941, "", 1'b1);
    drain(100);
    chk("drop_stays_sat", 32'(drop_cnt), 32'hFFFF);

    chk("pop_count", 32'(n_pops), 32'(exp_pops));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
